// File: rtl/text_area_writer.sv
// Write-side controller for the 8x8 text area cell store: takes character codes over
// valid/ready, tracks a cursor, and issues cell writes, row erases and full-screen clears.
module text_area_writer #(
  parameter int         COLS       = 84,
  parameter int         ROWS       = 64,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [7:0]  i_char,
  input  logic [3:0]  i_fg,
  input  logic [3:0]  i_bg,
  input  logic        i_cursor_set,
  input  logic [6:0]  i_cursor_col,
  input  logic [5:0]  i_cursor_row,
  output logic        o_we,
  output logic [12:0] o_addr,
  output logic [15:0] o_data,
  output logic [6:0]  o_cursor_col,
  output logic [5:0]  o_cursor_row,
  output logic        o_busy
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ERASE_ROW = 2'd1;
  localparam logic [1:0] S_CLEAR     = 2'd2;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [6:0] END_COL  = 7'(COLS);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  localparam logic [7:0] C_NUL = 8'h00;
  localparam logic [7:0] C_BS  = 8'h08;
  localparam logic [7:0] C_LF  = 8'h0A;
  localparam logic [7:0] C_FF  = 8'h0C;
  localparam logic [7:0] C_CR  = 8'h0D;

  logic [1:0] state;
  logic [6:0] seq_col;
  logic [5:0] seq_row;
  logic [3:0] attr_fg;
  logic [3:0] attr_bg;

  logic [6:0] eff_col;
  logic [5:0] eff_row;
  logic [5:0] next_row;

  // A cursor load in the same cycle as a code takes effect before the code is interpreted.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    eff_col = o_cursor_col;
    eff_row = o_cursor_row;
    if (i_cursor_set) begin
      eff_col = (i_cursor_col > LAST_COL) ? LAST_COL : i_cursor_col;
      eff_row = i_cursor_row & LAST_ROW;
    end
    next_row = (eff_row + 6'd1) & LAST_ROW;
  end

  assign o_busy = ~o_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      o_ready      <= 1'b1;
      o_we         <= 1'b0;
      o_addr       <= '0;
      o_data       <= '0;
      o_cursor_col <= '0;
      o_cursor_row <= '0;
      seq_col      <= '0;
      seq_row      <= '0;
      attr_fg      <= '0;
      attr_bg      <= '0;
    end else begin
      o_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_cursor_set) begin
            o_cursor_col <= eff_col;
            o_cursor_row <= eff_row;
          end
          if (i_valid) begin
            attr_fg <= i_fg;
            attr_bg <= i_bg;
            case (i_char)
              C_NUL: begin
              end
              C_BS: begin
                if (eff_col != 7'd0) o_cursor_col <= eff_col - 7'd1;
              end
              C_CR: begin
                o_cursor_col <= 7'd0;
              end
              C_LF: begin
                // Column 0 of the new row is written here; the sequence continues from column 1.
                o_cursor_row <= next_row;
                o_we         <= 1'b1;
                o_addr       <= {7'd0, next_row};
                o_data       <= {i_fg, i_bg, BLANK_CHAR};
                seq_col      <= 7'd1;
                seq_row      <= next_row;
                state        <= S_ERASE_ROW;
                o_ready      <= 1'b0;
              end
              C_FF: begin
                o_cursor_col <= 7'd0;
                o_cursor_row <= 6'd0;
                o_we         <= 1'b1;
                o_addr       <= '0;
                o_data       <= {i_fg, i_bg, BLANK_CHAR};
                if (LAST_ROW == 6'd0) begin
                  seq_col <= 7'd1;
                  seq_row <= 6'd0;
                end else begin
                  seq_col <= 7'd0;
                  seq_row <= 6'd1;
                end
                state   <= S_CLEAR;
                o_ready <= 1'b0;
              end
              default: begin
                o_we   <= 1'b1;
                o_addr <= {eff_col, eff_row};
                o_data <= {i_fg, i_bg, i_char};
                if (eff_col == LAST_COL) begin
                  // Auto-wrap: the whole new row is erased after the character lands.
                  o_cursor_col <= 7'd0;
                  o_cursor_row <= next_row;
                  seq_col      <= 7'd0;
                  seq_row      <= next_row;
                  state        <= S_ERASE_ROW;
                  o_ready      <= 1'b0;
                end else begin
                  o_cursor_col <= eff_col + 7'd1;
                end
              end
            endcase
          end
        end

        S_ERASE_ROW: begin
          if (seq_col == END_COL) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
          end else begin
            o_we    <= 1'b1;
            o_addr  <= {seq_col, seq_row};
            o_data  <= {attr_fg, attr_bg, BLANK_CHAR};
            seq_col <= seq_col + 7'd1;
          end
        end

        S_CLEAR: begin
          // Column-major walk; the column counter reaching COLS marks completion.
          if (seq_col == END_COL) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
          end else begin
            o_we   <= 1'b1;
            o_addr <= {seq_col, seq_row};
            o_data <= {attr_fg, attr_bg, BLANK_CHAR};
            if (seq_row == LAST_ROW) begin
              seq_row <= 6'd0;
              seq_col <= seq_col + 7'd1;
            end else begin
              seq_row <= seq_row + 6'd1;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_area_writer.sv
// Directed bench for text_area_writer: a vector table for single-cycle codes plus
// hand-written sequences for row erase, auto-wrap, clear and reset during clear.
module tb_text_area_writer;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_char;
  logic [3:0]  i_fg;
  logic [3:0]  i_bg;
  logic        i_cursor_set;
  logic [6:0]  i_cursor_col;
  logic [5:0]  i_cursor_row;
  logic        o_we;
  logic [12:0] o_addr;
  logic [15:0] o_data;
  logic [6:0]  o_cursor_col;
  logic [5:0]  o_cursor_row;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  text_area_writer dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_char       (i_char),
    .i_fg         (i_fg),
    .i_bg         (i_bg),
    .i_cursor_set (i_cursor_set),
    .i_cursor_col (i_cursor_col),
    .i_cursor_row (i_cursor_row),
    .o_we         (o_we),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .o_cursor_col (o_cursor_col),
    .o_cursor_row (o_cursor_row),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid;
    logic [7:0]  ch;
    logic [3:0]  fg;
    logic [3:0]  bg;
    logic        cset;
    logic [6:0]  ccol;
    logic [5:0]  crow;
    logic        we;
    logic [12:0] addr;
    logic [15:0] data;
    logic [6:0]  col;
    logic [5:0]  row;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [7:0] ch, input logic [3:0] fg,
                       input logic [3:0] bg, input logic cset, input logic [6:0] ccol,
                       input logic [5:0] crow);
    i_valid      = valid;
    i_char       = ch;
    i_fg         = fg;
    i_bg         = bg;
    i_cursor_set = cset;
    i_cursor_col = ccol;
    i_cursor_row = crow;
  endtask

  // Present inputs for exactly one edge, then sample the resulting cycle.
  task automatic apply(input logic valid, input logic [7:0] ch, input logic [3:0] fg,
                       input logic [3:0] bg, input logic cset, input logic [6:0] ccol,
                       input logic [5:0] crow);
    drive(valid, ch, fg, bg, cset, ccol, crow);
    @(posedge i_clk);
    #1;
    drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 7'd0, 6'd0);
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int k;
    int bad;

    drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 7'd0, 6'd0);
    i_rst = 1'b1;
    #23;
    check("rst_we", 32'(o_we), 0);
    check("rst_addr", 32'(o_addr), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_ready", 32'(o_ready), 1);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_col", 32'(o_cursor_col), 0);
    check("rst_row", 32'(o_cursor_row), 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    //          valid ch     fg    bg    cset ccol    crow  we addr      data      col    row
    vecs[0]  = '{1, 8'h41, 4'hF, 4'h1, 0, 7'd0,   6'd0, 1, 13'h000,  16'hF141, 7'd1,  6'd0};
    vecs[1]  = '{1, 8'h62, 4'h2, 4'h3, 0, 7'd0,   6'd0, 1, 13'h040,  16'h2362, 7'd2,  6'd0};
    vecs[2]  = '{1, 8'h00, 4'h5, 4'h5, 0, 7'd0,   6'd0, 0, 13'h000,  16'h0000, 7'd2,  6'd0};
    vecs[3]  = '{1, 8'h08, 4'h0, 4'h0, 0, 7'd0,   6'd0, 0, 13'h000,  16'h0000, 7'd1,  6'd0};
    vecs[4]  = '{1, 8'h08, 4'h0, 4'h0, 0, 7'd0,   6'd0, 0, 13'h000,  16'h0000, 7'd0,  6'd0};
    vecs[5]  = '{1, 8'h08, 4'h0, 4'h0, 0, 7'd0,   6'd0, 0, 13'h000,  16'h0000, 7'd0,  6'd0};
    vecs[6]  = '{0, 8'h00, 4'h0, 4'h0, 1, 7'd40,  6'd7, 0, 13'h000,  16'h0000, 7'd40, 6'd7};
    vecs[7]  = '{1, 8'h0D, 4'h0, 4'h0, 0, 7'd0,   6'd0, 0, 13'h000,  16'h0000, 7'd0,  6'd7};
    vecs[8]  = '{1, 8'h78, 4'h1, 4'h0, 1, 7'd50,  6'd9, 1, 13'h0C89, 16'h1078, 7'd51, 6'd9};
    vecs[9]  = '{0, 8'h00, 4'h0, 4'h0, 1, 7'd127, 6'd2, 0, 13'h000,  16'h0000, 7'd83, 6'd2};
    vecs[10] = '{0, 8'h51, 4'h9, 4'h9, 0, 7'd0,   6'd0, 0, 13'h000,  16'h0000, 7'd83, 6'd2};

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].valid, vecs[i].ch, vecs[i].fg, vecs[i].bg,
            vecs[i].cset, vecs[i].ccol, vecs[i].crow);
      check($sformatf("v%0d_we", i), 32'(o_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("v%0d_addr", i), 32'(o_addr), 32'(vecs[i].addr));
        check($sformatf("v%0d_data", i), 32'(o_data), 32'(vecs[i].data));
      end
      check($sformatf("v%0d_col", i), 32'(o_cursor_col), 32'(vecs[i].col));
      check($sformatf("v%0d_row", i), 32'(o_cursor_row), 32'(vecs[i].row));
      check($sformatf("v%0d_ready", i), 32'(o_ready), 1);
    end

    // Auto-wrap at column 83 followed by erase of row 6 with the latched attribute.
    drive(1'b1, 8'h5A, 4'h4, 4'h2, 1'b1, 7'd83, 6'd5);
    @(posedge i_clk);
    #1;
    drive(1'b1, 8'h51, 4'hE, 4'hD, 1'b0, 7'd0, 6'd0);
    check("wrap_we", 32'(o_we), 1);
    check("wrap_addr", 32'(o_addr), 32'h14C5);
    check("wrap_data", 32'(o_data), 32'h425A);
    check("wrap_ready", 32'(o_ready), 0);
    check("wrap_col", 32'(o_cursor_col), 0);
    check("wrap_row", 32'(o_cursor_row), 6);
    for (int c = 0; c < 84; c++) begin
      tick();
      if (c == 83) drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 7'd0, 6'd0);
      check($sformatf("wrap_erase%0d_we", c), 32'(o_we), 1);
      check($sformatf("wrap_erase%0d_addr", c), 32'(o_addr), 32'((c << 6) | 6));
      check($sformatf("wrap_erase%0d_data", c), 32'(o_data), 32'h4220);
      check($sformatf("wrap_erase%0d_ready", c), 32'(o_ready), 0);
    end
    tick();
    check("wrap_end_ready", 32'(o_ready), 1);
    check("wrap_end_we", 32'(o_we), 0);
    check("wrap_end_col", 32'(o_cursor_col), 0);
    check("wrap_end_row", 32'(o_cursor_row), 6);

    // LF on the last row wraps to row 0 and erases it.
    apply(1'b1, 8'h0A, 4'h7, 4'h0, 1'b1, 7'd10, 6'd63);
    check("lf_col", 32'(o_cursor_col), 10);
    check("lf_row", 32'(o_cursor_row), 0);
    for (int c = 0; c < 84; c++) begin
      if (c != 0) tick();
      check($sformatf("lf%0d_we", c), 32'(o_we), 1);
      check($sformatf("lf%0d_addr", c), 32'(o_addr), 32'(c << 6));
      check($sformatf("lf%0d_data", c), 32'(o_data), 32'h7020);
      check($sformatf("lf%0d_ready", c), 32'(o_ready), 0);
    end
    tick();
    check("lf_end_ready", 32'(o_ready), 1);
    check("lf_end_we", 32'(o_we), 0);

    // FF from a non-home cursor: 5376 column-major writes, addresses 0..5375 in order.
    apply(1'b1, 8'h0C, 4'h3, 4'h5, 1'b1, 7'd20, 6'd30);
    check("ff_col", 32'(o_cursor_col), 0);
    check("ff_row", 32'(o_cursor_row), 0);
    k = 0;
    bad = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (o_ready) break;
      if (o_we && o_addr == 13'(k) && o_data == 16'h3520) k++;
      else bad++;
      tick();
    end
    check("ff_pulses", 32'(k), 5376);
    check("ff_bad_cycles", 32'(bad), 0);
    check("ff_end_ready", 32'(o_ready), 1);
    check("ff_end_we", 32'(o_we), 0);

    // Asynchronous reset in the middle of a clear.
    apply(1'b1, 8'h0C, 4'h1, 4'h1, 1'b1, 7'd5, 6'd5);
    repeat (1000) tick();
    check("abort_pre_we", 32'(o_we), 1);
    #3;
    i_rst = 1'b1;
    #1;
    check("abort_we", 32'(o_we), 0);
    check("abort_ready", 32'(o_ready), 1);
    check("abort_col", 32'(o_cursor_col), 0);
    check("abort_row", 32'(o_cursor_row), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    apply(1'b1, 8'h42, 4'h1, 4'h2, 1'b0, 7'd0, 6'd0);
    check("after_we", 32'(o_we), 1);
    check("after_addr", 32'(o_addr), 0);
    check("after_data", 32'(o_data), 32'h1242);
    check("after_col", 32'(o_cursor_col), 1);
    tick();
    check("after_idle_we", 32'(o_we), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_area_writer.md
Name: text_area_writer

Overview:
- Write-side controller for the 8x8 text area cell store.
- Accepts a stream of character codes with a colour attribute from the CPU/bus side over a valid/ready handshake.
- Maintains a text cursor, interprets a small set of control codes, and issues single-cycle write strobes into the 84x64 cell RAM that the text renderer reads.
- Cell format and address layout match the renderer exactly: data = {fg[3:0], bg[3:0], char[7:0]}, address = {column[6:0], row[5:0]}.

Parameters:
- COLS, 84, number of text columns (valid column indices 0..COLS-1).
- ROWS, 64, number of text rows (valid row indices 0..ROWS-1; must be a power of two).
- BLANK_CHAR, 8'h20, character code written by clear and erase operations.

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  character/control code present on i_char.
- o_ready  output  1  block can accept a code or a cursor set this cycle.
- i_char  input  8  character or control code.
- i_fg  input  4  foreground palette index for this code.
- i_bg  input  4  background palette index for this code.
- i_cursor_set  input  1  load cursor from i_cursor_col/i_cursor_row.
- i_cursor_col  input  7  new cursor column.
- i_cursor_row  input  6  new cursor row.
- o_we  output  1  cell RAM write strobe, one cycle per cell.
- o_addr  output  13  cell RAM address {col, row}.
- o_data  output  16  cell RAM data {fg, bg, char}.
- o_cursor_col  output  7  current cursor column.
- o_cursor_row  output  6  current cursor row.
- o_busy  output  1  clear or erase sequence in progress; equals ~o_ready.

Behaviour:
- Reset (async, any state): state=IDLE; o_we=0; o_addr=0; o_data=0; cursor=(0,0); o_ready=1; o_busy=0. A clear or erase in progress is aborted and RAM is left partially written.
- States: IDLE, ERASE_ROW, CLEAR. o_ready=1 only in IDLE. All outputs are registered.
- Acceptance: a code is accepted on a rising edge where i_valid & o_ready; this edge is cycle N. Effects appear in cycle N+1.
- Cursor set: if i_cursor_set & o_ready, the cursor loads at the edge. Out-of-range values clamp: col to COLS-1, row is native 6 bits. If i_valid is also high, the code is processed using the newly loaded cursor.
- Printable code (anything other than 8'h00, 08, 0A, 0C, 0D):
  - Cycle N+1: o_we=1, o_addr={col,row}, o_data={i_fg,i_bg,i_char}.
  - Cursor col increments.
  - If col was COLS-1: col becomes 0, row becomes (row+1) mod ROWS, and the block enters ERASE_ROW for the new row after the char write.
  - Throughput in IDLE is one code per cycle.
- 8'h00 NUL: accepted, no write, cursor unchanged.
- 8'h08 BS: col decrements if col>0, else unchanged; no write.
- 8'h0D CR: col=0; no write.
- 8'h0A LF:
  - row=(row+1) mod ROWS; col unchanged.
  - Enter ERASE_ROW for the new row.
  - Writes {i_fg,i_bg,BLANK_CHAR} to col 0..COLS-1 in cycles N+1..N+COLS.
  - o_ready=0 during those cycles; o_ready=1 in cycle N+COLS+1.
- 8'h0C FF:
  - Cursor=(0,0).
  - Enter CLEAR: writes {i_fg,i_bg,BLANK_CHAR} to every cell, column-major (col 0 rows 0..63, then col 1, ...), in cycles N+1..N+COLS*ROWS (5376 cells).
  - Addresses never include col>=COLS.
  - o_ready returns in cycle N+COLS*ROWS+1.
- Auto-wrap erase: the char write occupies cycle N+1; erase writes occupy N+2..N+COLS+1; o_ready=0 from N+1 through N+COLS+1.
- Attribute for erase/clear is latched at acceptance; later changes to i_fg/i_bg do not affect the sequence.
- Row wrap: row 63 + LF -> row 0; erases row 0. No scrolling of content (scroll offset is managed by software).
- o_we is never high for two cycles at the same address within one sequence. o_we=0 whenever no write is issued.

Test Plan:
- Reset, then accept 'A'(8'h41), fg=F, bg=1 -> next cycle o_we=1, o_addr=0, o_data=16'hF141; cursor=(1,0).
- Cursor set (83,5), then 'Z' -> write at addr {83,5}=13'h14C5; then row-6 erase with addr {c,6} for c=0..83 over 84 cycles, o_ready low 85 cycles; cursor=(0,6).
- Cursor (10,63), LF with fg=7, bg=0 -> 84 writes of 16'h7020 to rows=0; cursor=(10,0); o_ready high at N+85.
- FF -> exactly 5376 o_we pulses, addresses 0..5375 in column-major {col,row} order, cursor=(0,0); o_ready held low throughout.
- BS at col 0 and CR at col 40 -> no o_we; cursor col stays 0, then becomes 0 respectively.
- Assert i_rst asynchronously midway through FF (after ~1000 writes) -> o_we drops immediately; cursor=(0,0); o_ready=1; next 'B' writes at addr 0.
